mmu_l1tlb_refill_ctrl: RTL and testbench
========================================

Name: mmu_l1tlb_refill_ctrl

Overview:
- Sequences L1 TLB refills after a miss.
- Arbitrates miss requests from the ITLB lookup port (requester 0) and the DTLB lookup port (requester 1), then issues one walk request to the L2 TLB/PTW and waits for the response.
- Drives the one-cycle L1 TLB write strobe (normal or super-page array); the same strobe feeds the L1 TLB PLRU replacement block, which supplies the write slot.
- Returns a completion pulse to the requester(s) that were served.

Parameters:
VPN_W, 20, virtual page number width (Sv32)
PPN_W, 22, physical page number width (Sv32)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
i_req_valid_2  input  2  per-requester miss request, level; held until served
i_req_vpn_0  input  VPN_W  requester 0 miss VPN
i_req_vpn_1  input  VPN_W  requester 1 miss VPN
i_flush  input  1  TLB flush / sfence; aborts the refill in flight
o_ptw_valid  output  1  walk request valid
i_ptw_ready  input  1  walk request accepted
o_ptw_vpn  output  VPN_W  walk VPN
i_ptw_resp_valid  input  1  walk response, single-cycle pulse
i_ptw_resp_ppn  input  PPN_W  translated PPN
i_ptw_resp_super  input  1  response is a 4 MiB superpage
i_ptw_resp_fault  input  1  page fault, no valid translation
o_write_en_2  output  2  bit0 normal-array write, bit1 super-array write; one-hot or zero
o_write_vpn  output  VPN_W  entry VPN tag
o_write_ppn  output  PPN_W  entry PPN
o_done_2  output  2  one-cycle completion pulse per served requester
o_done_fault  output  1  qualifies o_done_2: walk faulted
o_busy  output  1  FSM not in IDLE

Behaviour:
- Reset:
  - FSM goes to IDLE; round-robin pointer = 0; abort flag = 0.
  - All outputs 0: o_ptw_valid, o_write_en_2, o_done_2, o_done_fault, o_busy, o_ptw_vpn, o_write_vpn, o_write_ppn.
  - Reset mid-operation abandons the refill immediately. No write or done is issued, and any later PTW response is ignored because the FSM is in IDLE.
- FSM states: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE:
  - If i_flush is high, no grant that cycle.
  - Otherwise, if any i_req_valid_2 bit is set, grant one requester, latch its VPN into a vpn register, latch the grant mask, and go to REQ.
  - Round-robin rule: when both requesters are valid, grant the pointer's requester. After any grant, the pointer moves to the non-granted index (it flips when both were valid; it points at the other requester after a single grant).
  - Merge: when both are valid with equal VPNs, the grant mask is 2'b11, both are served by one walk, and the pointer is unchanged.
- REQ:
  - o_ptw_valid = 1 and o_ptw_vpn = latched VPN, both registered (first visible one cycle after the grant).
  - On i_ptw_ready go to WAIT.
  - On i_flush, if i_ptw_ready is also high, go to WAIT with abort flag = 1. Otherwise go to IDLE with no done.
- WAIT:
  - i_flush sets the abort flag.
  - On i_ptw_resp_valid: latch ppn, super and fault. If aborting (flag set, or i_flush in the same cycle), go to IDLE, clear the flag, and issue no write or done. If fault, go to DONE. Otherwise go to WRITE.
  - No timeout; the PTW guarantees a response.
- WRITE: for exactly one cycle, o_write_en_2 = super ? 2'b10 : 2'b01, with o_write_vpn and o_write_ppn valid. Then go to DONE. i_flush in WRITE does not cancel the write.
- DONE: for one cycle, o_done_2 = grant mask and o_done_fault = latched fault. Then go to IDLE.
- Requester protocol: a requester drops or changes valid in the cycle after its done pulse. IDLE re-arbitrates on that cycle.
- Latency (no stalls): request seen in IDLE at cycle 0 → o_ptw_valid at cycle 1. Response at cycle N → write at N+1, done at N+2. Next grant is possible at N+3.
- Only one refill is in flight at a time. i_ptw_resp_valid outside WAIT is ignored.

Test Plan:
- Single refill: req0 valid with vpn 0x12345; ready at cycle 1; response at cycle 4 with ppn 0x0ABCDE, super = 0 → o_write_en_2 = 01 at cycle 5 with vpn 0x12345 / ppn 0x0ABCDE; o_done_2 = 01 at cycle 6; o_busy drops at cycle 7.
- Round-robin: both requesters continuously valid with different VPNs, back-to-back → grants alternate 0, 1, 0, 1. Each write uses the granted requester's VPN, and each done is one-hot to that requester.
- Merge: both valid with vpn 0x00400, superpage response → exactly one walk, o_write_en_2 = 10, o_done_2 = 11.
- Fault: response with fault = 1 → no write cycle; o_done_2 = 10 with o_done_fault = 1 at response + 1.
- Flush: i_flush in REQ without ready → IDLE, no walk accepted. i_flush in WAIT, response 3 cycles later → no write and no done; the next request is served normally.
- Reset: assert rst during WAIT → all outputs 0 immediately; a later stray i_ptw_resp_valid produces no write or done.

Source files
------------

// File: rtl/mmu_l1tlb_refill_ctrl.sv
// L1 TLB refill sequencer: arbitrates ITLB/DTLB misses, issues one PTW walk,
// writes the returned entry into the L1 TLB and signals completion.
module mmu_l1tlb_refill_ctrl #(
    parameter int VPN_W = 20,
    parameter int PPN_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_req_valid_2,
    input  logic [VPN_W-1:0] i_req_vpn_0,
    input  logic [VPN_W-1:0] i_req_vpn_1,
    input  logic             i_flush,
    output logic             o_ptw_valid,
    input  logic             i_ptw_ready,
    output logic [VPN_W-1:0] o_ptw_vpn,
    input  logic             i_ptw_resp_valid,
    input  logic [PPN_W-1:0] i_ptw_resp_ppn,
    input  logic             i_ptw_resp_super,
    input  logic             i_ptw_resp_fault,
    output logic [1:0]       o_write_en_2,
    output logic [VPN_W-1:0] o_write_vpn,
    output logic [PPN_W-1:0] o_write_ppn,
    output logic [1:0]       o_done_2,
    output logic             o_done_fault,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             abort_q, abort_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [PPN_W-1:0] ppn_q, ppn_d;
    logic             super_q, super_d;
    logic             fault_q, fault_d;

    // State and refill context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            abort_q <= 1'b0;
            vpn_q   <= '0;
            gnt_q   <= '0;
            ppn_q   <= '0;
            super_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            abort_q <= abort_d;
            vpn_q   <= vpn_d;
            gnt_q   <= gnt_d;
            ppn_q   <= ppn_d;
            super_q <= super_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic: arbitration, walk handshake, abort tracking
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        abort_d = abort_q;
        vpn_d   = vpn_q;
        gnt_d   = gnt_q;
        ppn_d   = ppn_q;
        super_d = super_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (!i_flush && (|i_req_valid_2)) begin
                    state_d = REQ;
                    if (&i_req_valid_2) begin
                        if (i_req_vpn_0 == i_req_vpn_1) begin
                            // Same page missed on both ports: one walk serves both
                            gnt_d = 2'b11;
                            vpn_d = i_req_vpn_0;
                        end else if (rr_q) begin
                            gnt_d = 2'b10;
                            vpn_d = i_req_vpn_1;
                            rr_d  = 1'b0;
                        end else begin
                            gnt_d = 2'b01;
                            vpn_d = i_req_vpn_0;
                            rr_d  = 1'b1;
                        end
                    end else if (i_req_valid_2[0]) begin
                        gnt_d = 2'b01;
                        vpn_d = i_req_vpn_0;
                        rr_d  = 1'b1;
                    end else begin
                        gnt_d = 2'b10;
                        vpn_d = i_req_vpn_1;
                        rr_d  = 1'b0;
                    end
                end
            end
            REQ: begin
                if (i_flush) begin
                    // An accepted walk must still be drained, but its result dropped
                    if (i_ptw_ready) begin
                        state_d = WAIT;
                        abort_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (i_ptw_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_ptw_resp_valid) begin
                    ppn_d   = i_ptw_resp_ppn;
                    super_d = i_ptw_resp_super;
                    fault_d = i_ptw_resp_fault;
                    if (abort_q || i_flush) begin
                        state_d = IDLE;
                        abort_d = 1'b0;
                    end else if (i_ptw_resp_fault) begin
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                    end
                end else if (i_flush) begin
                    abort_d = 1'b1;
                end
            end
            WRITE: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_ptw_valid  = (state_q == REQ);
    assign o_ptw_vpn    = vpn_q;
    assign o_write_en_2 = (state_q == WRITE) ? (super_q ? 2'b10 : 2'b01) : 2'b00;
    assign o_write_vpn  = vpn_q;
    assign o_write_ppn  = ppn_q;
    assign o_done_2     = (state_q == DONE) ? gnt_q : 2'b00;
    assign o_done_fault = (state_q == DONE) && fault_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mmu_l1tlb_refill_ctrl.sv
// Scoreboard bench for the L1 TLB refill sequencer: stimulus pushes expected
// walks/writes/dones; a negedge monitor pops and compares on DUT outputs.
module tb_mmu_l1tlb_refill_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  i_req_valid_2;
    logic [19:0] i_req_vpn_0;
    logic [19:0] i_req_vpn_1;
    logic        i_flush;
    logic        o_ptw_valid;
    logic        i_ptw_ready;
    logic [19:0] o_ptw_vpn;
    logic        i_ptw_resp_valid;
    logic [21:0] i_ptw_resp_ppn;
    logic        i_ptw_resp_super;
    logic        i_ptw_resp_fault;
    logic [1:0]  o_write_en_2;
    logic [19:0] o_write_vpn;
    logic [21:0] o_write_ppn;
    logic [1:0]  o_done_2;
    logic        o_done_fault;
    logic        o_busy;

    mmu_l1tlb_refill_ctrl #(.VPN_W(20), .PPN_W(22)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req_valid_2    (i_req_valid_2),
        .i_req_vpn_0      (i_req_vpn_0),
        .i_req_vpn_1      (i_req_vpn_1),
        .i_flush          (i_flush),
        .o_ptw_valid      (o_ptw_valid),
        .i_ptw_ready      (i_ptw_ready),
        .o_ptw_vpn        (o_ptw_vpn),
        .i_ptw_resp_valid (i_ptw_resp_valid),
        .i_ptw_resp_ppn   (i_ptw_resp_ppn),
        .i_ptw_resp_super (i_ptw_resp_super),
        .i_ptw_resp_fault (i_ptw_resp_fault),
        .o_write_en_2     (o_write_en_2),
        .o_write_vpn      (o_write_vpn),
        .o_write_ppn      (o_write_ppn),
        .o_done_2         (o_done_2),
        .o_done_fault     (o_done_fault),
        .o_busy           (o_busy)
    );

    typedef struct {
        logic [1:0]  en;
        logic [19:0] vpn;
        logic [21:0] ppn;
        int          cyc;
    } wexp_t;

    typedef struct {
        logic [1:0] mask;
        logic       fault;
        int         cyc;
    } dexp_t;

    logic [19:0] pq[$];
    wexp_t       wq[$];
    dexp_t       dq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every walk handshake, write strobe and done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (o_ptw_valid && i_ptw_ready) begin
                if (pq.size() == 0) chk("unexpected_walk", 64'(o_ptw_vpn), 64'hFFFFFFFF);
                else chk("walk_vpn", 64'(o_ptw_vpn), 64'(pq.pop_front()));
            end
            if (o_write_en_2 != 2'b00) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 64'(o_write_en_2), 64'd0);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    chk("write_en_vpn_ppn", {20'd0, o_write_en_2, o_write_vpn, o_write_ppn},
                        {20'd0, w.en, w.vpn, w.ppn});
                    chk("write_cycle", 64'(cyc), 64'(w.cyc));
                end
            end
            if (o_done_2 != 2'b00) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 64'(o_done_2), 64'd0);
                end else begin
                    dexp_t d;
                    d = dq.pop_front();
                    chk("done_mask_fault", {61'd0, o_done_2, o_done_fault},
                        {61'd0, d.mask, d.fault});
                    chk("done_cycle", 64'(cyc), 64'(d.cyc));
                end
            end else if (o_done_fault) begin
                chk("fault_without_done", 64'(o_done_fault), 64'd0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Serve one walk: wait for request, accept, respond after dly cycles in WAIT
    task automatic do_walk(input logic [19:0] vpn, input logic [21:0] ppn,
                           input logic sup, input logic flt, input int dly,
                           input logic [1:0] wen, input logic [1:0] dmask,
                           output int done_cyc);
        int n;
        n = 0;
        while (!o_ptw_valid && n < 20) begin
            tick();
            n++;
        end
        chk("ptw_valid_seen", 64'(o_ptw_valid), 64'd1);
        done_cyc = cyc;
        if (o_ptw_valid) begin
            pq.push_back(vpn);
            i_ptw_ready = 1'b1;
            tick();
            i_ptw_ready = 1'b0;
            repeat (dly) tick();
            i_ptw_resp_valid = 1'b1;
            i_ptw_resp_ppn   = ppn;
            i_ptw_resp_super = sup;
            i_ptw_resp_fault = flt;
            if (!flt) wq.push_back('{en: wen, vpn: vpn, ppn: ppn, cyc: cyc + 1});
            done_cyc = flt ? cyc + 1 : cyc + 2;
            dq.push_back('{mask: dmask, fault: flt, cyc: done_cyc});
            tick();
            i_ptw_resp_valid = 1'b0;
            i_ptw_resp_fault = 1'b0;
            i_ptw_resp_super = 1'b0;
        end
    endtask

    task automatic wait_after_done(input int done_cyc);
        int n;
        n = 0;
        while (cyc < done_cyc + 1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int d;
        rst = 1'b1;
        i_req_valid_2 = 2'b00;
        i_req_vpn_0 = '0;
        i_req_vpn_1 = '0;
        i_flush = 1'b0;
        i_ptw_ready = 1'b0;
        i_ptw_resp_valid = 1'b0;
        i_ptw_resp_ppn = '0;
        i_ptw_resp_super = 1'b0;
        i_ptw_resp_fault = 1'b0;
        tick();
        tick();
        chk("rst_ptw_valid", 64'(o_ptw_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_write_en", 64'(o_write_en_2), 64'd0);
        chk("rst_done", 64'({o_done_2, o_done_fault}), 64'd0);
        chk("rst_vpn_ppn", {2'd0, o_ptw_vpn, o_write_vpn, o_write_ppn}, 64'd0);
        rst = 1'b0;
        tick();

        // Single refill, requester 0
        i_req_valid_2 = 2'b01;
        i_req_vpn_0 = 20'h12345;
        tick();
        do_walk(20'h12345, 22'h0ABCDE, 1'b0, 1'b0, 2, 2'b01, 2'b01, d);
        wait_after_done(d - 1);
        chk("single_busy_in_done", 64'(o_busy), 64'd1);
        wait_after_done(d);
        chk("single_busy_drop", 64'(o_busy), 64'd0);
        i_req_valid_2 = 2'b00;
        tick();

        // Round robin: both continuously valid, distinct VPNs
        do_reset();
        i_req_vpn_0 = 20'h0AAA0;
        i_req_vpn_1 = 20'h0BBB0;
        i_req_valid_2 = 2'b11;
        do_walk(20'h0AAA0, 22'h000111, 1'b0, 1'b0, 1, 2'b01, 2'b01, d);
        do_walk(20'h0BBB0, 22'h000222, 1'b0, 1'b0, 1, 2'b01, 2'b10, d);
        do_walk(20'h0AAA0, 22'h000333, 1'b1, 1'b0, 0, 2'b10, 2'b01, d);
        do_walk(20'h0BBB0, 22'h000444, 1'b0, 1'b0, 2, 2'b01, 2'b10, d);
        wait_after_done(d);
        i_req_valid_2 = 2'b00;
        tick();

        // Merge: equal VPNs on both ports, superpage
        i_req_vpn_0 = 20'h00400;
        i_req_vpn_1 = 20'h00400;
        i_req_valid_2 = 2'b11;
        do_walk(20'h00400, 22'h3FFC00, 1'b1, 1'b0, 0, 2'b10, 2'b11, d);
        wait_after_done(d);
        i_req_valid_2 = 2'b00;
        repeat (3) tick();
        chk("merge_single_walk", 64'({o_ptw_valid, o_busy}), 64'd0);

        // Fault on requester 1: no write, done at response + 1
        i_req_vpn_1 = 20'h0F00D;
        i_req_valid_2 = 2'b10;
        do_walk(20'h0F00D, 22'h000000, 1'b0, 1'b1, 1, 2'b00, 2'b10, d);
        wait_after_done(d);
        i_req_valid_2 = 2'b00;
        tick();

        // Flush in REQ without ready
        i_req_vpn_0 = 20'h00777;
        i_req_valid_2 = 2'b01;
        tick();
        chk("flreq_ptw_valid", 64'(o_ptw_valid), 64'd1);
        i_flush = 1'b1;
        i_req_valid_2 = 2'b00;
        tick();
        i_flush = 1'b0;
        chk("flreq_idle", 64'({o_ptw_valid, o_busy}), 64'd0);
        repeat (2) tick();
        chk("flreq_stays_idle", 64'(o_busy), 64'd0);

        // Flush in WAIT, response three cycles later is dropped
        i_req_vpn_0 = 20'h0AAAA;
        i_req_valid_2 = 2'b01;
        tick();
        chk("flwait_ptw_valid", 64'(o_ptw_valid), 64'd1);
        pq.push_back(20'h0AAAA);
        i_ptw_ready = 1'b1;
        tick();
        i_ptw_ready = 1'b0;
        i_req_valid_2 = 2'b00;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        repeat (2) tick();
        chk("flwait_still_busy", 64'(o_busy), 64'd1);
        i_ptw_resp_valid = 1'b1;
        i_ptw_resp_ppn = 22'h155555;
        tick();
        i_ptw_resp_valid = 1'b0;
        chk("flwait_idle", 64'(o_busy), 64'd0);
        repeat (3) tick();
        i_req_vpn_1 = 20'h0BBBB;
        i_req_valid_2 = 2'b10;
        do_walk(20'h0BBBB, 22'h2AAAAA, 1'b0, 1'b0, 1, 2'b01, 2'b10, d);
        wait_after_done(d);
        i_req_valid_2 = 2'b00;
        tick();

        // Reset during WAIT, then a stray response
        i_req_vpn_0 = 20'h01111;
        i_req_valid_2 = 2'b01;
        tick();
        pq.push_back(20'h01111);
        i_ptw_ready = 1'b1;
        tick();
        i_ptw_ready = 1'b0;
        i_req_valid_2 = 2'b00;
        tick();
        chk("rstwait_busy", 64'(o_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstwait_ctl", 64'({o_ptw_valid, o_write_en_2, o_done_2,
                                o_done_fault, o_busy}), 64'd0);
        chk("rstwait_data", {2'd0, o_ptw_vpn, o_write_vpn, o_write_ppn}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        i_ptw_resp_valid = 1'b1;
        i_ptw_resp_ppn = 22'h000999;
        tick();
        i_ptw_resp_valid = 1'b0;
        repeat (3) tick();
        chk("rstwait_stray_idle", 64'(o_busy), 64'd0);

        chk("walk_queue_empty", 64'(pq.size()), 64'd0);
        chk("write_queue_empty", 64'(wq.size()), 64'd0);
        chk("done_queue_empty", 64'(dq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
